axis_red_pitaya_dac_tx: RTL
===========================

Name: axis_red_pitaya_dac_tx

Overview:
Transmit-side counterpart of the ADC capture path. It accepts packed two-channel sample pairs from an AXI-Stream slave port and buffers them in a 2-entry FIFO. Each sample is saturated from 16-bit two's complement to the DAC width and converted to offset binary. Channels A and B are time-multiplexed onto the single Red Pitaya DAC data bus, with select, write and reset strobes; a start-up mute sequence runs before live data and underruns are counted.

Parameters:
DAC_WIDTH, 14, DAC data bus width (bits per channel at the pins)
AXIS_TDATA_WIDTH, 32, stream word width; channel A = [15:0], channel B = [31:16]
MUTE_CYCLES, 16, aclk cycles of midscale output after enable before live data (even, >=2)
CNT_WIDTH, 16, underrun counter width

Ports:
aclk  in  1  system clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run transmitter, 0 = stop and flush
s_axis_tdata  in  AXIS_TDATA_WIDTH  {chB, chA}, each 16-bit two's complement
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
dac_dat  out  DAC_WIDTH  offset-binary DAC word
dac_sel  out  1  1 = dac_dat carries channel A, 0 = channel B
dac_wrt  out  1  DAC write strobe
dac_rst  out  1  DAC reset, active high
running  out  1  1 while in RUN state
underrun_cnt  out  CNT_WIDTH  saturating count of RUN-state pops from an empty FIFO

Behaviour:
- Reset values (async, aresetn=0):
  - State IDLE; FIFO empty; phase=0.
  - pair_reg = {MID, MID}, where MID = 1<<(DAC_WIDTH-1) = 14'h2000.
  - dac_dat=MID, dac_sel=1, dac_wrt=0, dac_rst=1, running=0, underrun_cnt=0, s_axis_tready=0.
- States:
  - IDLE: dac_rst=1, dac_wrt=0, tready=0, FIFO held empty, phase held 0, pair_reg=MID.
    - enable=1 -> MUTE; mute counter cleared.
  - MUTE: dac_rst=0, dac_wrt=1, outputs carry MID, FIFO may prefill, no pops. Mute counter increments each cycle.
    - Counter = MUTE_CYCLES-1 with phase=1 -> RUN.
  - RUN: live data; running=1.
  - Any state, enable=0 -> IDLE on the next edge; FIFO flushed; pair_reg=MID; underrun_cnt retained.
- Phase: toggles every cycle in MUTE and RUN. The phase 1->0 edge is the pair boundary.
- Handshake:
  - s_axis_tready = (state!=IDLE) && (fifo_count<2), registered-free combinational from state and count.
  - A beat is accepted when tvalid && tready.
  - Simultaneous push and pop at count 1 leaves count at 1.
  - No push is possible at count 2.
- Pop (RUN only, on each phase 1->0 edge):
  - FIFO non-empty: pair_reg <= converted head entry.
  - FIFO empty: pair_reg holds its previous value (last pair repeated) and underrun_cnt increments, saturating at all-ones.
- Conversion (per channel, combinational at FIFO output):
  - x > 2^(DAC_WIDTH-1)-1 -> max; x < -2^(DAC_WIDTH-1) -> min; otherwise truncate to DAC_WIDTH bits.
  - Then invert the MSB. Examples: +8191 -> 3FFF, -8192 -> 0000, 0 -> 2000.
- Output stage (registered from pair_reg and phase):
  - Phase=0 cycle: next edge drives dac_dat=pair_reg.A, dac_sel=1.
  - Phase=1 cycle: next edge drives dac_dat=pair_reg.B, dac_sel=0.
  - Latency from pop edge to A on dac_dat is 1 cycle; B follows the cycle after.
  - dac_wrt=1 in MUTE and RUN.
- First RUN pair: the pop occurs on the MUTE->RUN transition edge.
- aresetn assertion mid-operation: immediate return to reset values; any buffered data is discarded.

Decomposition:
- Shared package red_pitaya_dac_pkg:
  - State enum (IDLE, MUTE, RUN).
  - DAC_MID constant.
  - Function sat_offset_bin(16-bit in) -> DAC_WIDTH out.
- One natural sub-module: axis_skid_fifo2 (2-entry FIFO with count, push, pop, flush), reusable on other stream paths.

Test Plan:
- Reset/idle: aresetn=0, then 1 with enable=0 -> dac_rst=1, dac_wrt=0, dac_dat=2000, tready=0 indefinitely.
- Mute then run: enable=1, stream A=0x1000, B=0xF000 continuously -> 16 cycles of 2000, then alternating dac_dat 3000 (sel=1) / 1000 (sel=0); running=1; underrun_cnt=0.
- Saturation: A=0x7FFF, B=0x8000 -> 3FFF (sel=1), 0000 (sel=0); A=0x1FFF, B=0xE000 -> 3FFF, 0000; A=0 -> 2000.
- Underrun: in RUN, send one pair (A=0x0100, B=0xFF00), then deassert tvalid for 3 pair periods -> 2100/1F00 repeated; underrun_cnt=3; tready stays 1.
- Backpressure: tvalid=1 constantly -> exactly one beat accepted per 2 cycles in RUN, FIFO count never exceeds 2, no beat lost or duplicated (scoreboard against sent sequence).
- Stop and restart: enable=0 mid-RUN with FIFO full -> next cycle IDLE, dac_rst=1, FIFO empty; re-enable -> full mute sequence repeats and underrun_cnt is retained.

Source files
------------

// File: rtl/red_pitaya_dac_pkg.sv
// Shared types and helpers for the Red Pitaya DAC transmit path.
// Sample conversion from 16-bit two's complement to saturated offset binary.
package red_pitaya_dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUTE,
    RUN
  } dac_state_t;

  localparam int DAC_WIDTH_DEFAULT = 14;
  localparam logic [DAC_WIDTH_DEFAULT-1:0] DAC_MID = 14'h2000;

  // Midscale code for an arbitrary DAC width, returned in 16 bits.
  function automatic logic [15:0] dac_mid(input int width);
    return 16'(1 << (width - 1));
  endfunction

  // Result occupies the low 'width' bits; callers truncate to their DAC width.
  function automatic logic [15:0] sat_offset_bin(input logic [15:0] x, input int width);
    int sx;
    int hi;
    int lo;
    int r;
    logic [31:0] u;
    sx = int'(signed'(x));
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (sx > hi)      r = hi;
    else if (sx < lo) r = lo;
    else              r = sx;
    u = 32'(r) ^ (32'd1 << (width - 1));
    u = u & ((32'd1 << width) - 32'd1);
    return u[15:0];
  endfunction

endpackage

// File: rtl/axis_red_pitaya_dac_tx_fifo.sv
// Two-entry FIFO with occupancy count and synchronous flush.
// Entry 0 is always the head, so the read side needs no pointer.
module axis_skid_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == 2'd0);
  assign do_push   = push && (count != 2'd2);
  assign do_pop    = pop && !empty;
  assign head_data = slot0;

  // Push-and-pop together can only happen at count 1, so the new word becomes the head.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          slot0 <= push_data;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/axis_red_pitaya_dac_tx.sv
// AXI-Stream to Red Pitaya DAC transmitter: buffers sample pairs, converts them to
// offset binary and interleaves channels A/B on one bus after a start-up mute.
module axis_red_pitaya_dac_tx
  import red_pitaya_dac_pkg::*;
#(
  parameter int DAC_WIDTH        = DAC_WIDTH_DEFAULT,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MUTE_CYCLES      = 16,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [DAC_WIDTH-1:0]        dac_dat,
  output logic                        dac_sel,
  output logic                        dac_wrt,
  output logic                        dac_rst,
  output logic                        running,
  output logic [CNT_WIDTH-1:0]        underrun_cnt
);

  localparam int MUTE_CNT_W = (MUTE_CYCLES > 2) ? $clog2(MUTE_CYCLES) : 1;
  localparam logic [DAC_WIDTH-1:0] MID = DAC_WIDTH'(dac_mid(DAC_WIDTH));

  dac_state_t                  state;
  dac_state_t                  state_nxt;
  logic                        phase;
  logic [MUTE_CNT_W-1:0]       mute_cnt;
  logic                        mute_done;
  logic                        pop_slot;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_flush;
  logic                        fifo_empty;
  logic [1:0]                  fifo_count;
  logic [AXIS_TDATA_WIDTH-1:0] fifo_head;
  logic [DAC_WIDTH-1:0]        conv_a;
  logic [DAC_WIDTH-1:0]        conv_b;
  logic [DAC_WIDTH-1:0]        pair_a;
  logic [DAC_WIDTH-1:0]        pair_b;

  assign mute_done  = (state == MUTE) && phase &&
                      (mute_cnt == MUTE_CNT_W'(MUTE_CYCLES - 1));
  // The MUTE->RUN edge is itself the first pair boundary, so it pops like RUN does.
  assign pop_slot   = enable && phase && ((state == RUN) || mute_done);
  assign fifo_push  = s_axis_tvalid && s_axis_tready;
  assign fifo_pop   = pop_slot && !fifo_empty;
  assign fifo_flush = !enable || (state == IDLE);

  assign conv_a = DAC_WIDTH'(sat_offset_bin(fifo_head[15:0], DAC_WIDTH));
  assign conv_b = DAC_WIDTH'(sat_offset_bin(fifo_head[31:16], DAC_WIDTH));

  axis_skid_fifo2 #(
    .WIDTH(AXIS_TDATA_WIDTH)
  ) u_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_data(s_axis_tdata),
    .pop      (fifo_pop),
    .head_data(fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = MUTE;
        MUTE:    if (mute_done) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    dac_rst       = (state == IDLE);
    dac_wrt       = (state != IDLE);
    running       = (state == RUN);
    s_axis_tready = (state != IDLE) && (fifo_count < 2'd2);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase    <= 1'b0;
      mute_cnt <= '0;
    end else begin
      phase    <= (enable && (state != IDLE)) ? ~phase : 1'b0;
      mute_cnt <= (state == MUTE) ? mute_cnt + 1'b1 : '0;
    end
  end

  // An empty pop keeps the previous pair on the pins so the DAC holds its level.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pair_a       <= MID;
      pair_b       <= MID;
      underrun_cnt <= '0;
    end else begin
      if (fifo_flush) begin
        pair_a <= MID;
        pair_b <= MID;
      end else if (fifo_pop) begin
        pair_a <= conv_a;
        pair_b <= conv_b;
      end
      if (pop_slot && fifo_empty && (underrun_cnt != {CNT_WIDTH{1'b1}})) begin
        underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dac_dat <= MID;
      dac_sel <= 1'b1;
    end else begin
      dac_dat <= phase ? pair_b : pair_a;
      dac_sel <= ~phase;
    end
  end

endmodule
